systolic_feeder: RTL
====================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand width in bits.
REQ-002 Parameter ARRAY_DIM, default 4, rows and columns of the square systolic array being fed (>=2).
REQ-003 Parameter K_MAX, default 16, maximum inner-dimension beats per matmul; KW = $clog2(K_MAX+1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 pause  input  1  freeze request from the warp scheduler.
REQ-007 start  input  1  begin a matmul; sampled only in IDLE.
REQ-008 k_len  input  KW  beat count for this matmul; sampled with start.
REQ-009 in_valid  input  1  beat offered; in_ready  output  1  beat accepted when both are high at a clock edge.
REQ-010 a_in  input  ARRAY_DIM x DATA_WIDTH  one A column slice; lane i feeds array row i.
REQ-011 b_in  input  ARRAY_DIM x DATA_WIDTH  one B row slice; lane j feeds array column j.
REQ-012 left_out / top_out  output  ARRAY_DIM x DATA_WIDTH  skewed operands to the array edges.
REQ-013 left_valid / top_valid  output  ARRAY_DIM  per-lane operand valid.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 matmul_done  output  1  single-cycle completion pulse.

Function
REQ-016 FSM states IDLE, FEED, DRAIN, DONE; IDLE->FEED on start with k_len in 1..K_MAX, k_len latched.
REQ-017 start with k_len = 0 or k_len > K_MAX is ignored; FSM stays IDLE.
REQ-018 start outside IDLE is ignored.
REQ-019 in_ready = (state == FEED) && !pause; no beat is accepted in IDLE, even if start and in_valid coincide.
REQ-020 Lane i of an accepted beat appears on left_out[i]/top_out[i], valid high, i+1 cycles after the accepting edge (lane 0 is a one-cycle register).
REQ-021 A FEED cycle without acceptance injects a bubble: valid low on every lane, each at its own skew delay.
REQ-022 After the k_len-th acceptance, FSM enters DRAIN with a counter of 2*ARRAY_DIM-2, decremented each unpaused cycle.
REQ-023 At counter zero, FSM moves to DONE; in DONE matmul_done = 1 for exactly one cycle, then IDLE.
REQ-024 While pause = 1, every register, including FSM, counters and skew lines, holds its value; outputs hold unchanged; matmul_done is not emitted or repeated.
REQ-025 Total unpaused latency from the last acceptance to matmul_done is 2*ARRAY_DIM-1 cycles.

Reset
REQ-026 reset low asynchronously forces IDLE, clears counters and skew lines, and drives all outputs to 0.
REQ-027 reset mid-matmul aborts it; no matmul_done pulse follows; first cycle after release is IDLE.

Configuration
REQ-028 With FEEDER_STALL_CNT_EN defined, adds output stall_cycles (16 bits): cleared on accepted start; increments on each unpaused FEED cycle with in_valid low; saturates at 16'hFFFF; reset value 0.
REQ-029 Without FEEDER_STALL_CNT_EN, the port and its counter are absent; all other behaviour is identical.

Structure
REQ-030 Package feeder_pkg holds the FSM state enum, default DATA_WIDTH/ARRAY_DIM/K_MAX constants, and the stall-counter width.
REQ-031 Sub-module skew_line (parameters DEPTH, DATA_WIDTH; hold-on-pause) implements one lane's data+valid delay; instantiated 2*ARRAY_DIM times with DEPTH = i+1.

Verification (ARRAY_DIM=4, DATA_WIDTH=16)
REQ-032 start, k_len=2, beats a_in={1,2,3,4} then {5,6,7,8} back-to-back -> left_out[0]=1,5 at +1,+2 cycles; left_out[3]=4,8 at +4,+5; matmul_done 7 cycles after the second acceptance.
REQ-033 k_len=3 with one in_valid-low cycle between beats 1 and 2 -> valid hole on every lane at its skew offset; with the macro, stall_cycles=1.
REQ-034 pause high 3 cycles in DRAIN -> outputs frozen, in_ready=0, matmul_done delayed exactly 3 cycles and pulses once.
REQ-035 start with k_len=0, then start during FEED -> both ignored; busy and state unchanged.
REQ-036 reset asserted after the first of 4 beats -> all outputs 0 immediately; no matmul_done; next start completes normally.

Source files
------------

// File: rtl/feeder_pkg.sv
// feeder_pkg: shared types and defaults for the systolic array operand feeder.
package feeder_pkg;

  // Controller phases for one matmul
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ARRAY_DIM  = 4;
  localparam int DEF_K_MAX      = 16;
  localparam int STALL_CNT_W    = 16;

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// skew_line: one lane's data+valid delay line of DEPTH registers that freezes while hold is high.
module skew_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic [DATA_WIDTH-1:0] dst_data,
  output logic                  dst_valid
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_pipe;
  logic [DEPTH-1:0]                 valid_pipe;

  // Shift data and valid one stage per unheld cycle; reset empties the whole line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_pipe  <= '0;
      valid_pipe <= '0;
    end else if (!hold) begin
      data_pipe[0]  <= src_data;
      valid_pipe[0] <= src_valid;
      for (int s = 1; s < DEPTH; s++) begin
        data_pipe[s]  <= data_pipe[s-1];
        valid_pipe[s] <= valid_pipe[s-1];
      end
    end
  end

  assign dst_data  = data_pipe[DEPTH-1];
  assign dst_valid = valid_pipe[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: accepts K operand beats and skews each lane onto the edges of a
// square systolic array, then waits for the wavefront to drain before pulsing done.
// Optional feature: define FEEDER_STALL_CNT_EN to add the stall_cycles output.
module systolic_feeder
  import feeder_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int ARRAY_DIM  = DEF_ARRAY_DIM,
  parameter  int K_MAX      = DEF_K_MAX,
  localparam int KW         = $clog2(K_MAX + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 pause,
  input  logic                                 start,
  input  logic [KW-1:0]                        k_len,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [ARRAY_DIM-1:0][DATA_WIDTH-1:0] a_in,
  input  logic [ARRAY_DIM-1:0][DATA_WIDTH-1:0] b_in,
  output logic [ARRAY_DIM-1:0][DATA_WIDTH-1:0] left_out,
  output logic [ARRAY_DIM-1:0][DATA_WIDTH-1:0] top_out,
  output logic [ARRAY_DIM-1:0]                 left_valid,
  output logic [ARRAY_DIM-1:0]                 top_valid,
  output logic                                 busy,
  output logic                                 matmul_done
`ifdef FEEDER_STALL_CNT_EN
  , output logic [STALL_CNT_W-1:0]             stall_cycles
`endif
);

  localparam int            DCW        = $clog2(2 * ARRAY_DIM - 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(2 * ARRAY_DIM - 2);
  localparam logic [KW-1:0]  K_MAX_K    = KW'(K_MAX);

  feeder_state_e  state;
  feeder_state_e  state_next;
  logic [KW-1:0]  k_reg;
  logic [KW-1:0]  beat_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           start_ok;
  logic           accept;
  logic           beat_last;

  assign start_ok  = start && (k_len != '0) && (k_len <= K_MAX_K);
  assign accept    = in_ready && in_valid;
  assign beat_last = (beat_cnt == (k_reg - KW'(1)));

  // State register; pause freezes it by making the next state equal the current one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/status outputs
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    matmul_done = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (!pause && start_ok) begin
          state_next = FEED;
        end
      end
      FEED: begin
        in_ready = !pause;
        if (in_ready && in_valid && beat_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!pause && (drain_cnt == DCW'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!pause) begin
          matmul_done = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat and drain counters; the drain count reaches zero on the edge that enters DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_reg     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else if (!pause) begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            k_reg    <= k_len;
            beat_cnt <= '0;
          end
        end
        FEED: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_last) begin
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        DRAIN: drain_cnt <= drain_cnt - DCW'(1);
        default: ;
      endcase
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  // Count FEED cycles where the producer had nothing to offer, saturating at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (!pause) begin
      if (state == IDLE && start_ok) begin
        stall_cycles <= '0;
      end else if (state == FEED && !in_valid && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
    end
  end
`endif

  // Lane i is delayed i+1 cycles so operands meet the array as a diagonal wavefront
  for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
    skew_line #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew_a (
      .clk       (clk),
      .reset     (reset),
      .hold      (pause),
      .src_data  (accept ? a_in[i] : '0),
      .src_valid (accept),
      .dst_data  (left_out[i]),
      .dst_valid (left_valid[i])
    );

    skew_line #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew_b (
      .clk       (clk),
      .reset     (reset),
      .hold      (pause),
      .src_data  (accept ? b_in[i] : '0),
      .src_valid (accept),
      .dst_data  (top_out[i]),
      .dst_valid (top_valid[i])
    );
  end

endmodule
